// File: rtl/fb_scan_reader.sv
// fb_scan_reader: raster-order frame-buffer read master with a 2-cycle latency pipe and a credit-limited skid FIFO
module fb_scan_reader #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int DATA_SIZE  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    output logic                        busy_o,
    output logic                        frame_done_o,
    output logic                        rd_en_o,
    output logic [18:0]                 rd_addr_o,
    input  logic signed [DATA_SIZE-1:0] rd_data_i,
    output logic                        pix_valid_o,
    input  logic                        pix_ready_i,
    output logic signed [DATA_SIZE-1:0] pix_data_o,
    output logic [9:0]                  pix_x_o,
    output logic [8:0]                  pix_y_o,
    output logic                        pix_sof_o,
    output logic                        pix_eol_o
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = 21;
    localparam int EW = DATA_SIZE + TW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [18:0]   addr_q, addr_d;
    logic [9:0]    x_q, x_d;
    logic [8:0]    y_q, y_d;
    logic          p1_v_q, p2_v_q;
    logic [TW-1:0] p1_tag_q, p2_tag_q;
    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          credit, issue, last_col, last_px, pop, done;

    // Reads in flight are counted against FIFO space so a full FIFO can always absorb them.
    assign credit       = int'(count_q) + int'(p1_v_q) + int'(p2_v_q) < FIFO_DEPTH;
    assign last_col     = x_q == 10'(WIDTH - 1);
    assign last_px      = last_col && y_q == 9'(HEIGHT - 1);
    assign issue        = state_q == RUN && credit;
    assign pix_valid_o  = count_q != '0;
    assign pop          = pix_valid_o && pix_ready_i;
    assign done         = state_q == DRAIN && !p1_v_q && !p2_v_q &&
                          (count_q == '0 || (count_q == {{AW{1'b0}}, 1'b1} && pop));
    assign busy_o       = state_q != IDLE;
    assign frame_done_o = done;
    assign rd_en_o      = issue;
    assign rd_addr_o    = addr_q;
    assign count_d      = count_q + {{AW{1'b0}}, p2_v_q} - {{AW{1'b0}}, pop};
    assign {pix_data_o, pix_x_o, pix_y_o, pix_sof_o, pix_eol_o} = mem_q[rd_ptr_q];

    // Scan sequencing: start in IDLE arms the walk, each issued read advances the raster position.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        x_d     = x_q;
        y_d     = y_q;
        if (state_q == IDLE && start_i) begin
            state_d = RUN;
            addr_d  = '0;
            x_d     = '0;
            y_d     = '0;
        end
        if (issue) begin
            addr_d  = addr_q + 19'd1;
            x_d     = last_col ? 10'd0 : x_q + 10'd1;
            y_d     = last_col ? y_q + 9'd1 : y_q;
            state_d = last_px ? DRAIN : RUN;
        end
        if (done) state_d = IDLE;
    end

    // Control state, tag pipe matching the RAM latency, and FIFO pointers.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            x_q      <= '0;
            y_q      <= '0;
            p1_v_q   <= 1'b0;
            p2_v_q   <= 1'b0;
            p1_tag_q <= '0;
            p2_tag_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            x_q      <= x_d;
            y_q      <= y_d;
            p1_v_q   <= issue;
            p2_v_q   <= p1_v_q;
            p1_tag_q <= {x_q, y_q, addr_q == '0, last_col};
            p2_tag_q <= p1_tag_q;
            wr_ptr_q <= wr_ptr_q + AW'(p2_v_q);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_d;
        end
    end

    // FIFO storage: only a stage-2 valid captures rd_data, so stale RAM output never enters.
    always_ff @(posedge clock_i) begin
        if (p2_v_q) mem_q[wr_ptr_q] <= {rd_data_i, p2_tag_q};
    end
endmodule

// File: tb/tb_fb_scan_reader.sv
// tb_fb_scan_reader: randomized-backpressure bench with a raster-order pixel reference model
module tb_fb_scan_reader;
    localparam int W  = 8;
    localparam int H  = 4;
    localparam int FD = 4;
    localparam int N  = W * H;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              busy, frame_done, rd_en, pix_valid, pix_sof, pix_eol;
    logic              pix_ready = 1'b1;
    logic [18:0]       rd_addr;
    logic signed [3:0] rd_data = '0;
    logic signed [3:0] pix_data;
    logic [9:0]        pix_x;
    logic [8:0]        pix_y;
    logic              r1_en = 1'b0;
    logic [18:0]       r1_addr = '0;

    int tests = 0, fails = 0;
    int acc_total = 0, issued_total = 0, done_cnt = 0;
    int frame_base = 0, lost_base = 0;
    bit rnd_mode = 1'b0, hold_ready = 1'b1, stall = 1'b0;
    int held = 0;

    fb_scan_reader #(.WIDTH(W), .HEIGHT(H), .DATA_SIZE(4), .FIFO_DEPTH(FD)) dut (
        .clock_i(clk), .reset_i(rst), .start_i(start), .busy_o(busy),
        .frame_done_o(frame_done), .rd_en_o(rd_en), .rd_addr_o(rd_addr),
        .rd_data_i(rd_data), .pix_valid_o(pix_valid), .pix_ready_i(pix_ready),
        .pix_data_o(pix_data), .pix_x_o(pix_x), .pix_y_o(pix_y),
        .pix_sof_o(pix_sof), .pix_eol_o(pix_eol)
    );

    always #5 clk = ~clk;

    // RAM model: mem[a] = a mod 16, two-cycle read latency, output holds when idle.
    always @(posedge clk) begin
        if (r1_en) rd_data <= 4'(r1_addr % 16);
        r1_en   <= rd_en;
        r1_addr <= rd_addr;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        if (obs != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int pix_val(input int k);
        return (k % 16) >= 8 ? (k % 16) - 16 : k % 16;
    endfunction

    // Monitor: every accepted pixel is compared to the k-th raster position of the frame.
    always @(negedge clk) begin
        if (rst) stall = 1'b0;
        else begin
            int k;
            if (stall) begin
                chk("hold_valid", int'(pix_valid), 1);
                chk("hold_data", int'({pix_data, pix_x, pix_y, pix_sof, pix_eol}), held);
            end
            if (rd_en) issued_total++;
            chk("outstanding_ok", int'(issued_total - acc_total - lost_base <= FD), 1);
            if (pix_valid && pix_ready) begin
                k = acc_total - frame_base;
                chk("pix_data", int'(pix_data), pix_val(k));
                chk("pix_x", int'(pix_x), k % W);
                chk("pix_y", int'(pix_y), k / W);
                chk("pix_sof", int'(pix_sof), int'(k == 0));
                chk("pix_eol", int'(pix_eol), int'(k % W == W - 1));
                acc_total++;
            end
            if (frame_done) begin
                done_cnt++;
                chk("done_after_last", acc_total - frame_base, N);
            end
            stall = pix_valid && !pix_ready;
            held  = int'({pix_data, pix_x, pix_y, pix_sof, pix_eol});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        pix_ready = rnd_mode ? 1'($urandom_range(0, 1)) : hold_ready;
    endtask

    task automatic go();
        frame_base = acc_total;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idx(input int n);
        int c = 0;
        while (acc_total - frame_base < n && c < 2000) begin
            tick();
            c++;
        end
        chk("wait_idx_timeout", int'(c < 2000), 1);
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        int c = 0;
        while (done_cnt == d0 && c < 2000) begin
            tick();
            c++;
        end
        chk("done_timeout", int'(done_cnt != d0), 1);
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(pix_valid), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        rst = 1'b0;
        tick();
        d0 = done_cnt;
        go();
        chk("c1_rd_en", int'(rd_en), 1);
        chk("c1_rd_addr", int'(rd_addr), 0);
        tick();
        tick();
        chk("c3_valid", int'(pix_valid), 0);
        tick();
        chk("c4_valid", int'(pix_valid), 1);
        chk("c4_data", int'(pix_data), 0);
        chk("c4_sof", int'(pix_sof), 1);
        wait_done();
        chk("f1_busy_after", int'(busy), 0);
        chk("f1_count", acc_total - frame_base, N);
        chk("f1_done_once", done_cnt - d0, 1);
        go();
        wait_idx(10);
        hold_ready = 1'b0;
        pix_ready = 1'b0;
        repeat (20) tick();
        chk("stall_rd_en", int'(rd_en), 0);
        chk("stall_valid", int'(pix_valid), 1);
        chk("stall_outstanding", issued_total - acc_total - lost_base, FD);
        hold_ready = 1'b1;
        pix_ready = 1'b1;
        wait_done();
        chk("f2_count", acc_total - frame_base, N);
        d0 = done_cnt;
        go();
        wait_idx(5);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        repeat (5) tick();
        chk("f3_count", acc_total - frame_base, N);
        chk("f3_done_once", done_cnt - d0, 1);
        chk("f3_no_restart", int'(busy), 0);
        rnd_mode = 1'b1;
        for (int f = 0; f < 6; f++) begin
            d0 = done_cnt;
            go();
            wait_done();
            repeat (3) tick();
            chk("rnd_count", acc_total - frame_base, N);
            chk("rnd_done_once", done_cnt - d0, 1);
        end
        rnd_mode = 1'b0;
        go();
        wait_idx(13);
        rst = 1'b1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_valid", int'(pix_valid), 0);
        chk("abort_done", int'(frame_done), 0);
        chk("abort_addr", int'(rd_addr), 0);
        tick();
        tick();
        rst = 1'b0;
        lost_base = issued_total - acc_total;
        tick();
        d0 = done_cnt;
        go();
        chk("restart_rd_en", int'(rd_en), 1);
        chk("restart_addr", int'(rd_addr), 0);
        wait_done();
        chk("restart_count", acc_total - frame_base, N);
        chk("restart_done_once", done_cnt - d0, 1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
